dm_host_link: RTL and testbench
===============================

// Module: dm_host_link
// PURPOSE
//  Host-side controller on the com port of the data-memory access selector.
//  Assembles UART RX bytes into 16-bit words and writes them to DM (status 00),
//  hands DM to the processor (status 01) until proc_done, then reads DM back
//  (status 10) and streams it out as TX bytes. Sits between UART and selector.
// PARAMETERS
//  LOAD_WORDS  256  words written to DM, addresses 0..LOAD_WORDS-1 (>=1)
//  DUMP_BASE   0    first DM address read back after the run
//  DUMP_WORDS  256  words read back and transmitted (>=1)
//  READ_LAT    1    cycles from com_addr valid to com_data_out valid (>=1)
// PORTS
//  clk           in   1   system clock, all logic on rising edge
//  rst_n         in   1   synchronous active-low reset
//  rx_data       in   8   received byte
//  rx_valid      in   1   1-cycle strobe, rx_data valid
//  tx_data       out  8   byte to transmit
//  tx_valid      out  1   tx_data valid; held until tx_ready
//  tx_ready      in   1   UART TX can accept byte
//  status        out  2   selector mode: 00 com write, 01 proc, 10 com read
//  com_data_in   out  16  write data to DM
//  com_addr      out  16  DM address
//  com_wr_en     out  1   DM write strobe
//  com_data_out  in   16  DM read data
//  proc_start    out  1   1-cycle pulse on entry to RUN
//  proc_done     in   1   processor finished; sampled only in RUN
//  busy          out  1   high in every state except IDLE
//  rx_overrun    out  1   sticky: byte received outside LOAD_LO/LOAD_HI
// BEHAVIOUR
//  - All outputs registered. Reset: status=00, com_addr=0, com_data_in=0,
//    com_wr_en=0, tx_valid=0, tx_data=0, proc_start=0, busy=0, rx_overrun=0,
//    state=IDLE, counters=0. Reset mid-operation aborts immediately, no flush.
//  - States: IDLE, LOAD_LO, LOAD_HI, FLUSH, RUN, RD_ADDR, RD_WAIT, TX_LO, TX_HI.
//  - IDLE (status 00): rx_valid -> latch low byte, go LOAD_HI.
//  - LOAD_LO: rx_valid -> latch low byte -> LOAD_HI.
//  - LOAD_HI: rx_valid -> next cycle com_data_in={rx_data,lo}, com_wr_en=1
//    for exactly 1 cycle at current com_addr; com_addr increments the cycle
//    after the strobe. Not last word -> LOAD_LO (byte accepted during the
//    strobe cycle is not lost). Last word -> FLUSH.
//  - FLUSH: strobe cycle, status stays 00 -> RUN. status never changes while
//    com_wr_en=1.
//  - RUN: status=01, proc_start pulses on first RUN cycle, com_wr_en=0.
//    proc_done high (any cycle incl. first) -> RD_ADDR, com_addr=DUMP_BASE.
//  - RD_ADDR: status=10, address driven; RD_WAIT holds READ_LAT cycles, then
//    captures com_data_out -> TX_LO.
//  - TX_LO/TX_HI: little-endian, low byte first. tx_valid=1 with tx_data
//    stable until cycle where tx_valid&tx_ready; then next byte or state.
//    After TX_HI handshake: addr+1 -> RD_ADDR, or after DUMP_WORDS -> IDLE
//    (status 00, busy 0).
//  - rx_valid in FLUSH/RUN/RD_*/TX_*: byte dropped, rx_overrun set (reset only).
//  - proc_done outside RUN ignored. com_addr is 16-bit, wraps 0xFFFF->0x0000.
// STRUCTURE
//  - Shared package dm_link_pkg: state enum; STATUS_COM_WR=2'b00,
//    STATUS_PROC=2'b01, STATUS_COM_RD=2'b10 (also used by the selector).
//  - One sub-module: dm_word_tx (16-bit word -> two-byte valid/ready
//    serializer), instantiated for TX_LO/TX_HI.
// TESTING (LOAD_WORDS=4, DUMP_WORDS=4, DUMP_BASE=0, READ_LAT=1)
//  - Bytes 34 12 78 56 BC 9A F0 DE -> writes 0x1234@0, 0x5678@1, 0x9ABC@2,
//    0xDEF0@3, one com_wr_en cycle each, then status=01, proc_start 1 pulse.
//  - Back-to-back rx_valid every cycle -> all 4 words written, no byte lost.
//  - proc_done after 10 RUN cycles -> status=10; TX bytes 34 12 78 56 BC 9A
//    F0 DE; tx_ready stalled 3 cycles on byte 2 -> tx_data held, no dup/loss.
//  - rx_valid during RUN -> rx_overrun=1, DM unchanged; proc_done in LOAD_* ignored.
//  - rst_n low for 1 cycle in TX_HI -> next cycle all outputs at reset values,
//    state IDLE; new load restarts at com_addr 0.

Source files
------------

// File: rtl/dm_link_pkg.sv
// Shared types and constants for the data-memory host link and the DM access selector.
package dm_link_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [1:0] STATUS_COM_WR = 2'b00;
    localparam logic [1:0] STATUS_PROC   = 2'b01;
    localparam logic [1:0] STATUS_COM_RD = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_LO,
        ST_LOAD_HI,
        ST_FLUSH,
        ST_RUN,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } dm_word_t;

    // Selector mode owned by each controller state.
    function automatic logic [1:0] status_of(input state_t s);
        case (s)
            ST_RUN:                                      return STATUS_PROC;
            ST_RD_ADDR, ST_RD_WAIT, ST_TX_LO, ST_TX_HI:  return STATUS_COM_RD;
            default:                                     return STATUS_COM_WR;
        endcase
    endfunction

endpackage

// File: rtl/dm_word_tx.sv
// Serializes one 16-bit word into two valid/ready bytes, low byte first.
module dm_word_tx
    import dm_link_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              fire_c
);

    dm_word_t          word_s;
    logic [BYTE_W-1:0] hi_q;
    logic              hi_phase;

    assign word_s = dm_word_t'(word);
    assign fire_c = tx_valid & tx_ready;

    // tx_data only moves on load or on an accepted byte, so it is stable while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            hi_q     <= '0;
            hi_phase <= 1'b0;
        end else if (load) begin
            tx_data  <= word_s.lo;
            hi_q     <= word_s.hi;
            tx_valid <= 1'b1;
            hi_phase <= 1'b0;
        end else if (fire_c) begin
            if (!hi_phase) begin
                tx_data  <= hi_q;
                hi_phase <= 1'b1;
            end else begin
                tx_valid <= 1'b0;
                hi_phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dm_host_link.sv
// Host-side DM controller: loads DM from UART bytes, hands DM to the processor,
// then reads DM back and streams it out over UART TX.
module dm_host_link
    import dm_link_pkg::*;
#(
    parameter int unsigned LOAD_WORDS = 256,
    parameter int unsigned DUMP_BASE  = 0,
    parameter int unsigned DUMP_WORDS = 256,
    parameter int unsigned READ_LAT   = 1
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [1:0]          status,
    output logic [WORD_W-1:0]   com_data_in,
    output logic [ADDR_W-1:0]   com_addr,
    output logic                com_wr_en,
    input  logic [WORD_W-1:0]   com_data_out,
    output logic                proc_start,
    input  logic                proc_done,
    output logic                busy,
    output logic                rx_overrun
);

    localparam int unsigned CNT_W  = 17;
    localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t              state, state_d;
    logic [BYTE_W-1:0]   lo_byte, lo_byte_d;
    logic [CNT_W-1:0]    word_cnt, word_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;

    logic [1:0]          status_d;
    logic [WORD_W-1:0]   com_data_in_d;
    logic [ADDR_W-1:0]   com_addr_d;
    logic                com_wr_en_d;
    logic                proc_start_d;
    logic                busy_d;
    logic                rx_overrun_d;

    logic                load_last_c;
    logic                dump_last_c;
    logic                wait_done_c;
    logic                tx_load_c;
    logic                tx_fire_c;

    assign load_last_c = (word_cnt == CNT_W'(LOAD_WORDS - 1));
    assign dump_last_c = (word_cnt == CNT_W'(DUMP_WORDS - 1));
    assign wait_done_c = (wait_cnt == WAIT_W'(READ_LAT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE, ST_LOAD_LO: if (rx_valid)    state_d = ST_LOAD_HI;
            ST_LOAD_HI:          if (rx_valid)    state_d = load_last_c ? ST_FLUSH : ST_LOAD_LO;
            ST_FLUSH:                             state_d = ST_RUN;
            ST_RUN:              if (proc_done)   state_d = ST_RD_ADDR;
            ST_RD_ADDR:                           state_d = ST_RD_WAIT;
            ST_RD_WAIT:          if (wait_done_c) state_d = ST_TX_LO;
            ST_TX_LO:            if (tx_fire_c)   state_d = ST_TX_HI;
            ST_TX_HI:            if (tx_fire_c)   state_d = dump_last_c ? ST_IDLE : ST_RD_ADDR;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        lo_byte_d     = lo_byte;
        word_cnt_d    = word_cnt;
        wait_cnt_d    = wait_cnt;
        com_data_in_d = com_data_in;
        com_addr_d    = com_addr;
        com_wr_en_d   = 1'b0;
        rx_overrun_d  = rx_overrun;
        tx_load_c     = 1'b0;
        status_d      = status_of(state_d);
        busy_d        = (state_d != ST_IDLE);
        proc_start_d  = (state_d == ST_RUN) && (state != ST_RUN);

        // Address advances the cycle after each write strobe.
        if (com_wr_en) begin
            com_addr_d = com_addr + 16'd1;
        end

        case (state)
            ST_IDLE, ST_LOAD_LO: begin
                if (rx_valid) lo_byte_d = rx_data;
            end
            ST_LOAD_HI: begin
                if (rx_valid) begin
                    com_data_in_d = {rx_data, lo_byte};
                    com_wr_en_d   = 1'b1;
                    word_cnt_d    = word_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (proc_done) begin
                    com_addr_d = ADDR_W'(DUMP_BASE);
                    word_cnt_d = '0;
                end
            end
            ST_RD_ADDR: begin
                wait_cnt_d = '0;
            end
            ST_RD_WAIT: begin
                if (wait_done_c) tx_load_c  = 1'b1;
                else             wait_cnt_d = wait_cnt + WAIT_W'(1);
            end
            ST_TX_HI: begin
                if (tx_fire_c) begin
                    if (dump_last_c) begin
                        com_addr_d = '0;
                        word_cnt_d = '0;
                    end else begin
                        com_addr_d = com_addr + 16'd1;
                        word_cnt_d = word_cnt + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (rx_valid && !(state inside {ST_IDLE, ST_LOAD_LO, ST_LOAD_HI})) begin
            rx_overrun_d = 1'b1;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status      <= STATUS_COM_WR;
            com_data_in <= '0;
            com_addr    <= '0;
            com_wr_en   <= 1'b0;
            proc_start  <= 1'b0;
            busy        <= 1'b0;
            rx_overrun  <= 1'b0;
            lo_byte     <= '0;
            word_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            status      <= status_d;
            com_data_in <= com_data_in_d;
            com_addr    <= com_addr_d;
            com_wr_en   <= com_wr_en_d;
            proc_start  <= proc_start_d;
            busy        <= busy_d;
            rx_overrun  <= rx_overrun_d;
            lo_byte     <= lo_byte_d;
            word_cnt    <= word_cnt_d;
            wait_cnt    <= wait_cnt_d;
        end
    end

    dm_word_tx u_word_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load_c),
        .word     (com_data_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .fire_c   (tx_fire_c)
    );

endmodule

// File: tb/tb_dm_host_link.sv
// Scoreboard bench for dm_host_link with a behavioural DM and UART model.
module tb_dm_host_link;
    import dm_link_pkg::*;

    localparam int unsigned LW = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned DB = 0;
    localparam int unsigned RL = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  status;
    logic [15:0] com_data_in;
    logic [15:0] com_addr;
    logic        com_wr_en;
    logic [15:0] com_data_out;
    logic        proc_start;
    logic        proc_done;
    logic        busy;
    logic        rx_overrun;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int pstart_cnt = 0;
    bit stall_pending = 1'b0;
    bit rand_ready = 1'b0;

    bit         prev_ok = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_pstart = 1'b0;

    always #5 clk = ~clk;

    dm_host_link #(
        .LOAD_WORDS (LW),
        .DUMP_BASE  (DB),
        .DUMP_WORDS (DW),
        .READ_LAT   (RL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .status       (status),
        .com_data_in  (com_data_in),
        .com_addr     (com_addr),
        .com_wr_en    (com_wr_en),
        .com_data_out (com_data_out),
        .proc_start   (proc_start),
        .proc_done    (proc_done),
        .busy         (busy),
        .rx_overrun   (rx_overrun)
    );

    // DM model: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (com_wr_en) mem[com_addr[7:0]] <= com_data_in;
        com_data_out <= mem[com_addr[7:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // TX ready pattern: one scripted 3-cycle stall on byte 2, otherwise random or always-ready.
    initial begin
        int hold;
        hold = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_pending && tx_valid && hs_count == 2) begin
                hold = 3;
                stall_pending = 1'b0;
            end
            if (hold > 0) begin
                tx_ready = 1'b0;
                hold--;
            end else if (rand_ready) begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write or a TX handshake.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (com_wr_en) begin
                check("wr_status", 32'(status), 32'(STATUS_COM_WR));
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_extra: got write 0x%0h@0x%0h, required none", com_data_in, com_addr);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(com_addr), 32'(e.addr));
                    check("wr_data", 32'(com_data_in), 32'(e.data));
                end
            end
            if (tx_valid && tx_ready) begin
                check("tx_status", 32'(status), 32'(STATUS_COM_RD));
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra: got byte 0x%0h, required none", tx_data);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
                hs_count++;
            end
            if (prev_ok && prev_valid && !prev_ready) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (proc_start) begin
                pstart_cnt++;
                check("pstart_status", 32'(status), 32'(STATUS_PROC));
                check("pstart_width", 32'(prev_pstart), 32'd0);
            end
        end
        prev_ok     = rst_n;
        prev_valid  = tx_valid;
        prev_ready  = tx_ready;
        prev_data   = tx_data;
        prev_pstart = proc_start;
    end

    task automatic check_reset(input string pfx);
        check({pfx, "_status"},     32'(status),      32'(STATUS_COM_WR));
        check({pfx, "_com_addr"},   32'(com_addr),    32'd0);
        check({pfx, "_com_data"},   32'(com_data_in), 32'd0);
        check({pfx, "_com_wr_en"},  32'(com_wr_en),   32'd0);
        check({pfx, "_tx_valid"},   32'(tx_valid),    32'd0);
        check({pfx, "_tx_data"},    32'(tx_data),     32'd0);
        check({pfx, "_proc_start"}, 32'(proc_start),  32'd0);
        check({pfx, "_busy"},       32'(busy),        32'd0);
        check({pfx, "_rx_overrun"}, 32'(rx_overrun),  32'd0);
    endtask

    task automatic wait_status(input logic [1:0] s, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (status !== s && n < budget);
        check(name, 32'(status), 32'(s));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || exp_tx.size() != 0) && n < budget);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_txq"}, 32'(exp_tx.size()), 32'd0);
        check({name, "_wrq"}, 32'(exp_wr.size()), 32'd0);
        check({name, "_status"}, 32'(status), 32'(STATUS_COM_WR));
    endtask

    // Words are little-endian byte pairs written to consecutive addresses from 0.
    task automatic load(input logic [7:0] b [8], input bit b2b, input int pd_at);
        for (int i = 0; i < int'(LW); i++) begin
            wr_t e;
            e.addr = 16'(i);
            e.data = {b[2*i+1], b[2*i]};
            exp_wr.push_back(e);
            ref_mem[i] = e.data;
        end
        for (int i = 0; i < int'(2 * LW); i++) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            if (i == pd_at) begin
                proc_done = 1'b1;
                tick();
                proc_done = 1'b0;
                @(negedge clk);
                check("pd_ignored", 32'(status), 32'(STATUS_COM_WR));
                tick();
            end else if (!b2b) begin
                repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    task automatic expect_dump();
        for (int i = 0; i < int'(DW); i++) begin
            exp_tx.push_back(ref_mem[DB + i][7:0]);
            exp_tx.push_back(ref_mem[DB + i][15:8]);
        end
        hs_count = 0;
    endtask

    task automatic rand_bytes(output logic [7:0] b [8]);
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes [8];
        int n;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        proc_done = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_reset("por");
        tick();
        rst_n = 1'b1;

        // Run 1: fixed pattern with gaps, stray proc_done in load, overrun in RUN, scripted stall.
        bytes = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        load(bytes, 1'b0, 3);
        wait_status(STATUS_PROC, 20, "run1_enter");
        check("run1_no_overrun", 32'(rx_overrun), 32'd0);
        tick();
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (8) tick();
        expect_dump();
        stall_pending = 1'b1;
        rand_ready    = 1'b0;
        proc_done     = 1'b1;
        tick();
        proc_done = 1'b0;
        @(negedge clk);
        check("run1_read_status", 32'(status), 32'(STATUS_COM_RD));
        check("run1_overrun", 32'(rx_overrun), 32'd1);
        wait_idle(400, "run1_end");
        check("run1_pstart", 32'(pstart_cnt), 32'd1);

        // Run 2: back-to-back random bytes, proc_done already high on the first RUN cycle.
        tick();
        rand_bytes(bytes);
        load(bytes, 1'b1, -1);
        expect_dump();
        rand_ready = 1'b1;
        proc_done  = 1'b1;
        wait_status(STATUS_COM_RD, 20, "run2_read");
        proc_done = 1'b0;
        wait_idle(600, "run2_end");
        check("run2_pstart", 32'(pstart_cnt), 32'd2);
        check("run2_overrun_sticky", 32'(rx_overrun), 32'd1);

        // Run 3: reset while the high byte of word 1 is presented.
        tick();
        rand_bytes(bytes);
        load(bytes, 1'b0, -1);
        wait_status(STATUS_PROC, 20, "run3_enter");
        tick();
        expect_dump();
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (hs_count < 3 && n < 400);
        check("run3_reach_tx_hi", 32'(hs_count), 32'd3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_tx.delete();
        @(negedge clk);
        check_reset("mid_tx");

        // Run 4: load after abort must restart at address 0.
        tick();
        rand_bytes(bytes);
        load(bytes, 1'b0, -1);
        wait_status(STATUS_PROC, 20, "run4_enter");
        repeat (3) tick();
        expect_dump();
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        wait_idle(600, "run4_end");
        check("run4_pstart", 32'(pstart_cnt), 32'd4);
        check("run4_overrun_clear", 32'(rx_overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
